// File: rtl/pixel_packer_if.sv
// Pixel-packer bus: camera/detection-side pixel stream in, BRAM write port out.
// master = pixel source / BRAM side, slave = pixel_packer.
interface pixel_packer_if #(
  parameter int ADDR_W = 17
);
  logic              valid_in;
  logic [10:0]       hcount_in;
  logic [9:0]        vcount_in;
  logic [15:0]       pixel_in;
  logic              thresh_in;
  logic              drawn_in;
  logic [1:0]        draw_color_in;
  logic [10:0]       cross_x_in;
  logic [9:0]        cross_y_in;
  logic [ADDR_W-1:0] addr_out;
  logic [7:0]        data_out;
  logic              we_out;
  logic              frame_done_out;

  modport master (
    output valid_in, hcount_in, vcount_in, pixel_in, thresh_in, drawn_in,
           draw_color_in, cross_x_in, cross_y_in,
    input  addr_out, data_out, we_out, frame_done_out
  );

  modport slave (
    input  valid_in, hcount_in, vcount_in, pixel_in, thresh_in, drawn_in,
           draw_color_in, cross_x_in, cross_y_in,
    output addr_out, data_out, we_out, frame_done_out
  );
endinterface

// File: rtl/pixel_packer.sv
// pixel_packer: classifies RGB565 camera pixels (drawn / crosshair / threshold /
// gray), packs them to 8 bits and issues frame-BRAM writes. Two register stages.
// Optional build macro: CROSSHAIR_BLINK_EN (crosshair hidden on frames where
// frame_counter[BLINK_BIT] is set).
module pixel_packer #(
  parameter int WIDTH     = 320,
  parameter int HEIGHT    = 240,
  parameter int ADDR_W    = 17,
  parameter int CROSS_ARM = 4,
  parameter int BLINK_BIT = 4
) (
  input logic           clk_in,
  input logic           rst_in,
  pixel_packer_if.slave bus
);

  localparam logic [10:0]        H_LIM  = 11'(WIDTH);
  localparam logic [9:0]         V_LIM  = 10'(HEIGHT);
  localparam logic [10:0]        H_LAST = 11'(WIDTH - 1);
  localparam logic [9:0]         V_LAST = 10'(HEIGHT - 1);
  localparam logic [10:0]        CX_RST = 11'(WIDTH / 2);
  localparam logic [9:0]         CY_RST = 10'(HEIGHT / 2);
  localparam logic signed [11:0] ARM_H  = 12'(CROSS_ARM);
  localparam logic signed [10:0] ARM_V  = 11'(CROSS_ARM);

  if (BLINK_BIT < 0 || BLINK_BIT > 7) begin : g_bad_blink_bit
    $error("BLINK_BIT must index the 8-bit frame counter");
  end
  if ((64'd1 << ADDR_W) < 64'(WIDTH * HEIGHT)) begin : g_bad_addr_w
    $error("ADDR_W too narrow for WIDTH*HEIGHT");
  end

  // Latched crosshair and stage registers
  logic [10:0]       cx_q;
  logic [9:0]        cy_q;
  logic              s1_valid;
  logic [10:0]       s1_h;
  logic [9:0]        s1_v;
  logic [5:0]        s1_luma;
  logic              s1_cross;
  logic              s1_thresh;
  logic              s1_drawn;
  logic [1:0]        s1_color;
  logic [ADDR_W-1:0] addr_q;
  logic [7:0]        data_q;
  logic              we_q;
  logic              done_q;

  // Stage-1 combinational terms
  logic              frame_start;
  logic [10:0]       cx_eff;
  logic [9:0]        cy_eff;
  logic              in_range;
  logic signed [11:0] dh;
  logic signed [10:0] dv;
  logic              hit;
  logic              cross_show;
  logic [5:0]        r6;
  logic [5:0]        b6;
  logic [5:0]        luma6;

  // Stage-2 combinational terms
  logic [7:0]        enc;
  logic [ADDR_W-1:0] addr_calc;
  logic              last_px;

`ifdef CROSSHAIR_BLINK_EN
  logic [7:0] frame_cnt;
  logic [7:0] frame_cnt_eff;

  // Frame counter; the frame-start pixel already sees the incremented value
  always_comb begin
    frame_cnt_eff = frame_start ? frame_cnt + 8'd1 : frame_cnt;
    cross_show    = ~frame_cnt_eff[BLINK_BIT];
  end

  // Frame counter register
  always_ff @(posedge clk_in) begin
    if (rst_in) frame_cnt <= '0;
    else        frame_cnt <= frame_cnt_eff;
  end
`else
  // Crosshair is shown on every frame
  always_comb cross_show = 1'b1;
`endif

  // Stage-1 classification: range, luma, crosshair hit (frame-start pixel uses new crosshair)
  always_comb begin
    frame_start = bus.valid_in && (bus.hcount_in == '0) && (bus.vcount_in == '0);
    cx_eff      = frame_start ? bus.cross_x_in : cx_q;
    cy_eff      = frame_start ? bus.cross_y_in : cy_q;
    in_range    = (bus.hcount_in < H_LIM) && (bus.vcount_in < V_LIM);
    dh          = $signed({1'b0, bus.hcount_in}) - $signed({1'b0, cx_eff});
    dv          = $signed({1'b0, bus.vcount_in}) - $signed({1'b0, cy_eff});
    hit         = ((dh == '0) && (dv <= ARM_V) && (dv >= -ARM_V)) ||
                  ((dv == '0) && (dh <= ARM_H) && (dh >= -ARM_H));
    r6          = {bus.pixel_in[15:11], bus.pixel_in[15]};
    b6          = {bus.pixel_in[4:0], bus.pixel_in[4]};
    luma6       = 6'(({2'b00, r6, 1'b0} + 9'(bus.pixel_in[10:5]) * 9'd5 + 9'(b6)) >> 3);
  end

  // Stage-1 registers and crosshair latch
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      cx_q      <= CX_RST;
      cy_q      <= CY_RST;
      s1_valid  <= 1'b0;
      s1_h      <= '0;
      s1_v      <= '0;
      s1_luma   <= '0;
      s1_cross  <= 1'b0;
      s1_thresh <= 1'b0;
      s1_drawn  <= 1'b0;
      s1_color  <= '0;
    end else begin
      cx_q      <= cx_eff;
      cy_q      <= cy_eff;
      s1_valid  <= bus.valid_in && in_range;
      s1_h      <= bus.hcount_in;
      s1_v      <= bus.vcount_in;
      s1_luma   <= luma6;
      s1_cross  <= hit && cross_show;
      s1_thresh <= bus.thresh_in;
      s1_drawn  <= bus.drawn_in;
      s1_color  <= bus.draw_color_in;
    end
  end

  // Stage-2 encode (drawn > crosshair > threshold > gray) and address
  always_comb begin
    enc = {2'b00, s1_luma};
    if (s1_drawn)       enc = {2'b11, s1_color, 4'b0000};
    else if (s1_cross)  enc = 8'h40;
    else if (s1_thresh) enc = 8'h80;
    addr_calc = ADDR_W'(s1_v) * ADDR_W'(WIDTH) + ADDR_W'(s1_h);
    last_px   = (s1_h == H_LAST) && (s1_v == V_LAST);
  end

  // Stage-2 write port registers; data/addr hold across bubbles
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      addr_q <= '0;
      data_q <= '0;
      we_q   <= 1'b0;
      done_q <= 1'b0;
    end else begin
      we_q   <= s1_valid;
      done_q <= s1_valid && last_px;
      if (s1_valid) begin
        addr_q <= addr_calc;
        data_q <= enc;
      end
    end
  end

  assign bus.addr_out       = addr_q;
  assign bus.data_out       = data_q;
  assign bus.we_out         = we_q;
  assign bus.frame_done_out = done_q;

endmodule

// File: tb/tb_pixel_packer.sv
// Directed self-checking bench for pixel_packer (WIDTH=320, HEIGHT=240).
module tb_pixel_packer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   passed = 0;
  int   total  = 0;

  always #5 clk = ~clk;

  pixel_packer_if #(.ADDR_W(17)) pif ();

  pixel_packer #(
    .WIDTH(320), .HEIGHT(240), .ADDR_W(17), .CROSS_ARM(4), .BLINK_BIT(4)
  ) dut (
    .clk_in (clk),
    .rst_in (rst),
    .bus    (pif)
  );

  task automatic put(input logic [10:0] h, input logic [9:0] v, input logic [15:0] p,
                     input logic th, input logic dr, input logic [1:0] col);
    @(negedge clk);
    pif.valid_in      = 1'b1;
    pif.hcount_in     = h;
    pif.vcount_in     = v;
    pif.pixel_in      = p;
    pif.thresh_in     = th;
    pif.drawn_in      = dr;
    pif.draw_color_in = col;
  endtask

  task automatic gap();
    @(negedge clk);
    pif.valid_in = 1'b0;
  endtask

  // one isolated pixel; returns at the negedge where its write is visible
  task automatic send(input logic [10:0] h, input logic [9:0] v, input logic [15:0] p,
                      input logic th, input logic dr, input logic [1:0] col);
    put(h, v, p, th, dr, col);
    gap();
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    total++; if (pif.we_out !== 1'b0) $display("FAIL reset_we: got %b want 0", pif.we_out); else passed++;
    total++; if (pif.data_out !== 8'h00) $display("FAIL reset_data: got %h want 00", pif.data_out); else passed++;
    total++; if (pif.addr_out !== 17'd0) $display("FAIL reset_addr: got %0d want 0", pif.addr_out); else passed++;
    total++; if (pif.frame_done_out !== 1'b0) $display("FAIL reset_done: got %b want 0", pif.frame_done_out); else passed++;
    rst = 1'b0;
  endtask

  task automatic test_gray();
    pif.cross_x_in = 11'd200; pif.cross_y_in = 10'd200;
    send(11'd0, 10'd0, 16'hFFFF, 1'b0, 1'b0, 2'b00);
    total++; if (pif.we_out !== 1'b1) $display("FAIL gray_we: got %b want 1", pif.we_out); else passed++;
    total++; if (pif.data_out !== 8'h3F) $display("FAIL gray_ffff: got %h want 3f", pif.data_out); else passed++;
    total++; if (pif.addr_out !== 17'd0) $display("FAIL gray_addr0: got %0d want 0", pif.addr_out); else passed++;
    @(negedge clk);
    total++; if (pif.we_out !== 1'b0) $display("FAIL bubble_we: got %b want 0", pif.we_out); else passed++;
    total++; if (pif.data_out !== 8'h3F) $display("FAIL bubble_hold: got %h want 3f", pif.data_out); else passed++;
    send(11'd1, 10'd0, 16'h0000, 1'b0, 1'b0, 2'b00);
    total++; if (pif.data_out !== 8'h00) $display("FAIL gray_zero: got %h want 00", pif.data_out); else passed++;
    total++; if (pif.addr_out !== 17'd1) $display("FAIL gray_addr1: got %0d want 1", pif.addr_out); else passed++;
    send(11'd2, 10'd0, 16'h8030, 1'b0, 1'b0, 2'b00);
    total++; if (pif.data_out !== 8'h0D) $display("FAIL gray_msb_expand: got %h want 0d", pif.data_out); else passed++;
    send(11'd3, 10'd0, 16'hF800, 1'b0, 1'b0, 2'b00);
    total++; if (pif.data_out !== 8'h0F) $display("FAIL gray_red: got %h want 0f", pif.data_out); else passed++;
    send(11'd4, 10'd0, 16'h07E0, 1'b0, 1'b0, 2'b00);
    total++; if (pif.data_out !== 8'h27) $display("FAIL gray_green: got %h want 27", pif.data_out); else passed++;
    send(11'd5, 10'd0, 16'h001F, 1'b0, 1'b0, 2'b00);
    total++; if (pif.data_out !== 8'h07) $display("FAIL gray_blue: got %h want 07", pif.data_out); else passed++;
  endtask

  task automatic test_priority();
    pif.cross_x_in = 11'd10; pif.cross_y_in = 10'd5;
    send(11'd0, 10'd0, 16'h0000, 1'b0, 1'b0, 2'b00);
    total++; if (pif.data_out !== 8'h00) $display("FAIL prio_fs_nohit: got %h want 00", pif.data_out); else passed++;
    send(11'd10, 10'd5, 16'hFFFF, 1'b1, 1'b1, 2'b11);
    total++; if (pif.data_out !== 8'hF0) $display("FAIL prio_drawn_red: got %h want f0", pif.data_out); else passed++;
    total++; if (pif.addr_out !== 17'd1610) $display("FAIL prio_addr: got %0d want 1610", pif.addr_out); else passed++;
    send(11'd10, 10'd5, 16'hFFFF, 1'b1, 1'b1, 2'b10);
    total++; if (pif.data_out !== 8'hE0) $display("FAIL prio_drawn_green: got %h want e0", pif.data_out); else passed++;
    send(11'd10, 10'd5, 16'hFFFF, 1'b1, 1'b0, 2'b11);
    total++; if (pif.data_out !== 8'h40) $display("FAIL prio_cross: got %h want 40", pif.data_out); else passed++;
    pif.cross_x_in = 11'd100; pif.cross_y_in = 10'd100;
    send(11'd0, 10'd0, 16'h0000, 1'b0, 1'b0, 2'b00);
    send(11'd10, 10'd5, 16'hFFFF, 1'b1, 1'b0, 2'b11);
    total++; if (pif.data_out !== 8'h80) $display("FAIL prio_thresh: got %h want 80", pif.data_out); else passed++;
  endtask

  task automatic test_cross_edge();
    pif.cross_x_in = 11'd0; pif.cross_y_in = 10'd0;
    send(11'd0, 10'd0, 16'hFFFF, 1'b0, 1'b0, 2'b00);
    total++; if (pif.data_out !== 8'h40) $display("FAIL cross_fs_new: got %h want 40", pif.data_out); else passed++;
    send(11'd4, 10'd0, 16'h0000, 1'b0, 1'b0, 2'b00);
    total++; if (pif.data_out !== 8'h40) $display("FAIL cross_h4: got %h want 40", pif.data_out); else passed++;
    send(11'd0, 10'd4, 16'h0000, 1'b0, 1'b0, 2'b00);
    total++; if (pif.data_out !== 8'h40) $display("FAIL cross_v4: got %h want 40", pif.data_out); else passed++;
    send(11'd5, 10'd0, 16'h0000, 1'b0, 1'b0, 2'b00);
    total++; if (pif.data_out !== 8'h00) $display("FAIL cross_h5: got %h want 00", pif.data_out); else passed++;
    send(11'd0, 10'd5, 16'h0000, 1'b0, 1'b0, 2'b00);
    total++; if (pif.data_out !== 8'h00) $display("FAIL cross_v5: got %h want 00", pif.data_out); else passed++;
    send(11'd319, 10'd0, 16'h0000, 1'b0, 1'b0, 2'b00);
    total++; if (pif.data_out !== 8'h00) $display("FAIL cross_nowrap: got %h want 00", pif.data_out); else passed++;
    pif.cross_x_in = 11'd319;
    send(11'd319, 10'd0, 16'h0000, 1'b0, 1'b0, 2'b00);
    total++; if (pif.data_out !== 8'h00) $display("FAIL cross_midframe_new: got %h want 00", pif.data_out); else passed++;
    send(11'd4, 10'd0, 16'h0000, 1'b0, 1'b0, 2'b00);
    total++; if (pif.data_out !== 8'h40) $display("FAIL cross_midframe_old: got %h want 40", pif.data_out); else passed++;
  endtask

  task automatic test_range_end();
    send(11'd320, 10'd0, 16'hFFFF, 1'b0, 1'b0, 2'b00);
    total++; if (pif.we_out !== 1'b0) $display("FAIL range_h320_we: got %b want 0", pif.we_out); else passed++;
    send(11'd0, 10'd240, 16'hFFFF, 1'b0, 1'b0, 2'b00);
    total++; if (pif.we_out !== 1'b0) $display("FAIL range_v240_we: got %b want 0", pif.we_out); else passed++;
    send(11'd318, 10'd239, 16'h0000, 1'b0, 1'b0, 2'b00);
    total++; if (pif.frame_done_out !== 1'b0) $display("FAIL end_notlast_done: got %b want 0", pif.frame_done_out); else passed++;
    total++; if (pif.addr_out !== 17'd76798) $display("FAIL end_notlast_addr: got %0d want 76798", pif.addr_out); else passed++;
    send(11'd319, 10'd239, 16'h0000, 1'b0, 1'b0, 2'b00);
    total++; if (pif.we_out !== 1'b1) $display("FAIL end_last_we: got %b want 1", pif.we_out); else passed++;
    total++; if (pif.addr_out !== 17'd76799) $display("FAIL end_last_addr: got %0d want 76799", pif.addr_out); else passed++;
    total++; if (pif.frame_done_out !== 1'b1) $display("FAIL end_last_done: got %b want 1", pif.frame_done_out); else passed++;
    @(negedge clk);
    total++; if (pif.frame_done_out !== 1'b0) $display("FAIL end_done_pulse: got %b want 0", pif.frame_done_out); else passed++;
  endtask

  task automatic test_back_to_back();
    logic [15:0] pix [3];
    logic [7:0]  exp_d [3];
    pix[0] = 16'hFFFF; pix[1] = 16'h0000; pix[2] = 16'hF800;
    exp_d[0] = 8'h3F;  exp_d[1] = 8'h00;  exp_d[2] = 8'h0F;
    for (int i = 0; i < 5; i++) begin
      if (i < 3) put(11'(2 + i), 10'd1, pix[i], 1'b0, 1'b0, 2'b00);
      else gap();
      if (i >= 2) begin
        total++; if (pif.we_out !== 1'b1) $display("FAIL b2b_we[%0d]: got %b want 1", i - 2, pif.we_out); else passed++;
        total++; if (pif.data_out !== exp_d[i-2]) $display("FAIL b2b_data[%0d]: got %h want %h", i - 2, pif.data_out, exp_d[i-2]); else passed++;
        total++; if (pif.addr_out !== 17'(322 + i - 2)) $display("FAIL b2b_addr[%0d]: got %0d want %0d", i - 2, pif.addr_out, 322 + i - 2); else passed++;
      end
    end
    @(negedge clk);
    total++; if (pif.we_out !== 1'b0) $display("FAIL b2b_tail_we: got %b want 0", pif.we_out); else passed++;
  endtask

  task automatic test_reset_mid();
    pif.cross_x_in = 11'd0; pif.cross_y_in = 10'd0;
    put(11'd5, 10'd2, 16'hFFFF, 1'b0, 1'b0, 2'b00);
    put(11'd6, 10'd2, 16'hFFFF, 1'b0, 1'b0, 2'b00);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; pif.valid_in = 1'b0;
    total++; if (pif.we_out !== 1'b0) $display("FAIL rstmid_we_n2: got %b want 0", pif.we_out); else passed++;
    total++; if (pif.data_out !== 8'h00) $display("FAIL rstmid_data: got %h want 00", pif.data_out); else passed++;
    total++; if (pif.addr_out !== 17'd0) $display("FAIL rstmid_addr: got %0d want 0", pif.addr_out); else passed++;
    @(negedge clk);
    total++; if (pif.we_out !== 1'b0) $display("FAIL rstmid_we_n3: got %b want 0", pif.we_out); else passed++;
    send(11'd164, 10'd120, 16'h0000, 1'b0, 1'b0, 2'b00);
    total++; if (pif.data_out !== 8'h40) $display("FAIL rstmid_centre_h: got %h want 40", pif.data_out); else passed++;
    send(11'd160, 10'd116, 16'h0000, 1'b0, 1'b0, 2'b00);
    total++; if (pif.data_out !== 8'h40) $display("FAIL rstmid_centre_v: got %h want 40", pif.data_out); else passed++;
    send(11'd165, 10'd120, 16'h0000, 1'b1, 1'b0, 2'b00);
    total++; if (pif.data_out !== 8'h80) $display("FAIL rstmid_centre_out: got %h want 80", pif.data_out); else passed++;
  endtask

`ifdef CROSSHAIR_BLINK_EN
  task automatic test_blink();
    logic [7:0] f;
    test_reset();
    pif.cross_x_in = 11'd0; pif.cross_y_in = 10'd0;
    for (int i = 1; i <= 47; i++) begin
      f = 8'(i);
      send(11'd0, 10'd0, 16'h0000, 1'b0, 1'b0, 2'b00);
      total++;
      if (pif.data_out !== (f[4] ? 8'h00 : 8'h40))
        $display("FAIL blink_frame%0d: got %h want %h", i, pif.data_out, (f[4] ? 8'h00 : 8'h40));
      else passed++;
    end
  endtask
`endif

  initial begin
    pif.valid_in = 1'b0; pif.hcount_in = '0; pif.vcount_in = '0; pif.pixel_in = '0;
    pif.thresh_in = 1'b0; pif.drawn_in = 1'b0; pif.draw_color_in = '0;
    pif.cross_x_in = 11'd200; pif.cross_y_in = 10'd200;
    test_reset();
    test_gray();
    test_priority();
    test_cross_edge();
    test_range_end();
    test_back_to_back();
    test_reset_mid();
`ifdef CROSSHAIR_BLINK_EN
    test_blink();
`endif
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/pixel_packer.md
Name: pixel_packer

Overview:
- Encoder for the 8-bit packed pixel format stored in the frame BRAM; the display-side decoder consumes this format.
- Takes camera RGB565 pixels plus per-pixel threshold-mask and draw-layer flags, together with the crosshair position.
- Classifies each pixel, encodes it to 8 bits and issues a BRAM write with a computed address.
- 2-stage pipeline; sits between the camera/detection path and the frame BRAM write port.

Parameters:
- WIDTH, 320, frame width in pixels
- HEIGHT, 240, frame height in pixels
- ADDR_W, 17, BRAM address width (must satisfy 2^ADDR_W >= WIDTH*HEIGHT)
- CROSS_ARM, 4, crosshair half-length in pixels
- BLINK_BIT, 4, frame-counter bit that gates the crosshair when blink is enabled

Ports:
- clk_in  input  1  system clock
- rst_in  input  1  synchronous active-high reset
- valid_in  input  1  pixel qualifier, one pixel per cycle max
- hcount_in  input  11  pixel column
- vcount_in  input  10  pixel row
- pixel_in  input  16  RGB565 camera pixel
- thresh_in  input  1  pixel passed the colour threshold
- drawn_in  input  1  pixel is set in the draw layer
- draw_color_in  input  2  pen colour code (00 yellow, 01 magenta, 10 green, 11 red)
- cross_x_in  input  11  crosshair centre column
- cross_y_in  input  10  crosshair centre row
- addr_out  output  ADDR_W  BRAM write address
- data_out  output  8  packed pixel
- we_out  output  1  BRAM write enable
- frame_done_out  output  1  one-cycle pulse with the write of the last pixel (WIDTH-1, HEIGHT-1)

Behaviour:
- Single clock, clk_in; rst_in is synchronous and active-high.
- Reset values:
  - addr_out=0, data_out=0, we_out=0, frame_done_out=0
  - both pipeline valid bits cleared
  - latched crosshair = (WIDTH/2, HEIGHT/2)
  - frame counter = 0
- Latency: valid_in at cycle N -> we_out at cycle N+2. Throughput is 1 pixel/cycle. There is no backpressure; the BRAM always accepts.
- Stage 1 (registered):
  - Range check: h<WIDTH && v<HEIGHT. An out-of-range pixel propagates with its valid bit cleared, so no write occurs.
  - Luma: expand r5 and b5 to 6 bits by appending their MSB; g6 is used as-is. luma6 = (2*r6 + 5*g6 + b6) >> 3, computed at 9 bits. Maximum result is 63, so no saturation is needed.
  - Crosshair hit when either holds:
    - h==cx and |v-cy|<=CROSS_ARM
    - v==cy and |h-cx|<=CROSS_ARM
  - Compute the differences signed, so that a crosshair near an edge does not wrap.
  - Register thresh_in, drawn_in and draw_color_in.
- Stage 2 (registered): encode with priority drawn > crosshair > threshold > gray:
  - drawn: {2'b11, draw_color_in, 4'b0000}, giving 0xC0, 0xD0, 0xE0, 0xF0
  - crosshair: 8'h40
  - threshold: 8'h80
  - gray: {2'b00, luma6}
- Address: addr_out = v*WIDTH + h, computed in stage 2 from the stage-1 registered coordinates.
- frame_done_out is asserted with the write of (WIDTH-1, HEIGHT-1).
- Crosshair latching:
  - cross_x_in/cross_y_in are sampled only when valid_in is high with h==0 and v==0 (frame start).
  - That pixel already uses the new values.
  - Mid-frame changes have no effect until the next frame start, which prevents tearing.
- Frame counter: 8-bit, increments on each frame-start pixel and wraps 255->0.
- Simultaneous events: frame start coinciding with a pipeline write does not disturb the in-flight writes.
- Reset mid-frame: in-flight pixels are discarded and no writes occur in the two cycles after reset deasserts unless valid_in is high. Crosshair state returns to centre.
- valid_in low: the pipeline bubble propagates; we_out is low for that slot. data_out and addr_out hold their last values.

Optional Feature:
- Macro: CROSSHAIR_BLINK_EN
- Defined: the crosshair category is suppressed on frames where frame_counter[BLINK_BIT]==1. Those pixels fall through to threshold/gray encoding. The counter value used is the one after the frame-start increment.
- Undefined: the crosshair is encoded on every frame and frame-counter logic may be removed. Behaviour must otherwise be identical.

Test Plan:
- Gray encode: pixel_in=16'hFFFF at (0,0), no flags -> 2 cycles later we_out=1, addr_out=0, data_out=8'h3F. Then pixel_in=0 at (1,0) -> data_out=8'h00, addr_out=1.
- Priority: at (10,5), drawn_in=1, draw_color_in=2'b11, thresh_in=1, crosshair at (10,5) -> data_out=8'hF0, addr_out=1610. Same pixel with drawn_in=0 -> 8'h40. Same pixel with crosshair moved away -> 8'h80.
- Crosshair latch and edge: frame start with cross=(0,0) -> pixels (4,0) and (0,4) give 8'h40; (5,0) gives gray; (WIDTH-1,0) is not a hit (no wrap). Changing cross_x_in mid-frame has no effect on the same frame.
- Range and frame end: pixel (320,0) -> no write. Pixel (319,239) -> addr_out=76799, frame_done_out=1 for exactly one cycle.
- Reset mid-stream: valid pixels at cycles N and N+1, rst_in at N+1 -> no we_out at N+2/N+3; outputs 0; crosshair back to (160,120).
- Blink (CROSSHAIR_BLINK_EN, BLINK_BIT=4): on frames 16-31 the crosshair pixel encodes as gray/threshold; on frames 0-15 and 32-47 it encodes as 8'h40.
